// File: rtl/count_event_capture.sv
// count_event_capture: extends a free-running 16-bit count into an epoch timestamp.
// It raises compare and trigger events, queues them in a small FIFO, and presents them on a valid/ready port.
`default_nettype none

module count_event_capture #(
  parameter int EPOCH_W    = 16,
  parameter int DEPTH      = 4,
  parameter int AUTO_REARM = 0
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [15:0]          count,
  input  logic [15:0]          cmp_value,
  input  logic                 cmp_load,
  input  logic                 cmp_cancel,
  input  logic                 trig,
  input  logic                 ovf_clr,
  output logic                 evt_valid,
  input  logic                 evt_ready,
  output logic [EPOCH_W+15:0]  evt_data,
  output logic                 evt_src,
  output logic [EPOCH_W-1:0]   epoch,
  output logic                 wrap_pulse,
  output logic                 armed,
  output logic                 overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = EPOCH_W + 16;
  localparam logic [AW:0] c_depth = (AW+1)'(DEPTH);

  typedef enum logic [0:0] {IDLE = 1'b0, ARMED = 1'b1} state_t;

  logic [15:0]        cnt_q;
  logic               prime_q;
  logic [EPOCH_W-1:0] epoch_q, epoch_d;
  logic               wrap_pulse_q;
  logic               wrap;
  logic [TW-1:0]      ts;

  state_t             state_q, state_d;
  logic [15:0]        cmp_q, cmp_d;
  logic               cmp_hit;

  logic [TW-1:0]      data_q [DEPTH];
  logic               src_q  [DEPTH];
  logic [AW-1:0]      rd_q, wr_q, cmp_idx;
  logic [AW:0]        occ_q, occ_d, free, free_after_trig;
  logic               pop, trig_acc, cmp_acc, drop;
  logic               overflow_q, overflow_d;

  // A drop below the previous sample means a wrap (or an upstream restart to zero).
  always_comb begin
    wrap    = prime_q && (count < cnt_q);
    epoch_d = epoch_q + EPOCH_W'(wrap);
    ts      = {epoch_d, count};
  end

  always_comb begin
    state_d = state_q;
    cmp_d   = cmp_q;
    cmp_hit = 1'b0;
    if (cmp_load) begin
      state_d = ARMED;
      cmp_d   = cmp_value;
    end else if (state_q == ARMED) begin
      if (cmp_cancel) begin
        state_d = IDLE;
      end else if (count == cmp_q) begin
        cmp_hit = 1'b1;
        state_d = (AUTO_REARM != 0) ? ARMED : IDLE;
      end
    end
  end

  // Free space is measured after this cycle's pop so a full FIFO can accept while draining.
  always_comb begin
    pop             = (occ_q != '0) && evt_ready;
    free            = c_depth - (occ_q - {{AW{1'b0}}, pop});
    trig_acc        = trig && (free != '0);
    free_after_trig = free - {{AW{1'b0}}, trig_acc};
    cmp_acc         = cmp_hit && (free_after_trig != '0);
    drop            = (trig && !trig_acc) || (cmp_hit && !cmp_acc);
    cmp_idx         = wr_q + AW'(trig_acc);
    occ_d           = occ_q - {{AW{1'b0}}, pop} + {{AW{1'b0}}, trig_acc} + {{AW{1'b0}}, cmp_acc};
    overflow_d      = drop || (overflow_q && !ovf_clr);
  end

  always_ff @(posedge clock) begin
    cnt_q <= count;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prime_q      <= 1'b0;
      epoch_q      <= '0;
      wrap_pulse_q <= 1'b0;
      state_q      <= IDLE;
      cmp_q        <= '0;
      rd_q         <= '0;
      wr_q         <= '0;
      occ_q        <= '0;
      overflow_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
        src_q[i]  <= 1'b0;
      end
    end else begin
      prime_q      <= 1'b1;
      epoch_q      <= epoch_d;
      wrap_pulse_q <= wrap;
      state_q      <= state_d;
      cmp_q        <= cmp_d;
      rd_q         <= rd_q + AW'(pop);
      wr_q         <= wr_q + AW'(trig_acc) + AW'(cmp_acc);
      occ_q        <= occ_d;
      overflow_q   <= overflow_d;
      if (trig_acc) begin
        data_q[wr_q] <= ts;
        src_q[wr_q]  <= 1'b0;
      end
      if (cmp_acc) begin
        data_q[cmp_idx] <= ts;
        src_q[cmp_idx]  <= 1'b1;
      end
    end
  end

  assign evt_valid  = (occ_q != '0);
  assign evt_data   = data_q[rd_q];
  assign evt_src    = src_q[rd_q];
  assign epoch      = epoch_q;
  assign wrap_pulse = wrap_pulse_q;
  assign armed      = (state_q == ARMED);
  assign overflow   = overflow_q;

endmodule

`default_nettype wire
